i2s_rx: RTL and testbench

//  I2S (Philips) serial-audio receiver; the inbound counterpart of the j1a i2s transmitter.

---
 rtl/i2s_rx_pkg.sv | 10 +
 rtl/i2s_rx_sync_edge.sv | 33 +++
 rtl/i2s_rx.sv | 98 +++++++++
 tb/tb_i2s_rx.sv | 125 ++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared constants, state type and counter sizing for the I2S receiver
package i2s_rx_pkg;
  localparam int WIDTH_DEF = 16;
  localparam logic CH_LEFT = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/i2s_rx_sync_edge.sv
// i2s_rx_sync_edge: N-bit multi-stage synchroniser with aligned output register and rise pulse on bit 0
module i2s_rx_sync_edge #(
  parameter int N = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  output logic [N-1:0] q,
  output logic         rise
);
  logic [STAGES-1:0][N-1:0] sync_q, sync_d;
  logic [N-1:0] q_q, q_d;
  logic rise_q, rise_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    q_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1][0] & ~q_q[0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      q_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      q_q <= q_d;
      rise_q <= rise_d;
    end
  end
  assign q = q_q;
  assign rise = rise_q;
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver deserialising MSB-first slots into left/right pairs over valid/ready
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             lrclk,
  input  logic             sdin,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             frame_err
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  logic [2:0] pins_s;
  logic sclk_rise, lr, d, unused_sclk;
  i2s_rx_sync_edge #(.N(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  ({sdin, lrclk, sclk}),
    .q    (pins_s),
    .rise (sclk_rise)
  );
  assign unused_sclk = pins_s[0];
  assign lr = pins_s[1];
  assign d = pins_s[2];
  state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, l_hold_q, l_hold_d, left_q, left_d, right_q, right_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic ch_q, ch_d, lr_prev_q, lr_prev_d, have_l_q, have_l_d;
  logic valid_q, valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic locked, room, done, edge_lr, short_slot, new_pair, load;
  always_ff @(posedge clk) begin
    if (reset) state_q <= UNLOCKED;
    else state_q <= state_d;
  end
  always_comb begin
    locked = state_q == LOCKED;
    room = cnt_q < FULL;
    cnt_inc = room ? cnt_q + 1'b1 : cnt_q;
    edge_lr = sclk_rise & (lr != lr_prev_q);
    done = sclk_rise & room & (cnt_inc == FULL);
    short_slot = edge_lr & locked & (cnt_inc != FULL);
    new_pair = locked & done & (ch_q == CH_RIGHT) & have_l_q;
    load = new_pair & (!valid_q | ready);
    state_d = edge_lr ? LOCKED : state_q;
    shreg_d = (sclk_rise & room) ? {shreg_q[WIDTH-2:0], d} : shreg_q;
    cnt_d = edge_lr ? '0 : sclk_rise ? cnt_inc : cnt_q;
    ch_d = edge_lr ? lr : ch_q;
    lr_prev_d = sclk_rise ? lr : lr_prev_q;
    l_hold_d = (locked & done & (ch_q == CH_LEFT)) ? shreg_d : l_hold_q;
    have_l_d = short_slot ? 1'b0 : (locked & done) ? (ch_q == CH_LEFT) : have_l_q;
    left_d = load ? l_hold_q : left_q;
    right_d = load ? shreg_d : right_q;
    valid_d = load | (valid_q & !ready);
    overrun_d = overrun_q | (new_pair & valid_q & !ready);
    frame_err_d = frame_err_q | short_slot;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      l_hold_q <= '0;
      left_q <= '0;
      right_q <= '0;
      cnt_q <= '0;
      ch_q <= CH_LEFT;
      lr_prev_q <= 1'b0;
      have_l_q <= 1'b0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      l_hold_q <= l_hold_d;
      left_q <= left_d;
      right_q <= right_d;
      cnt_q <= cnt_d;
      ch_q <= ch_d;
      lr_prev_q <= lr_prev_d;
      have_l_q <= have_l_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign left = left_q;
  assign right = right_q;
  assign valid = valid_q;
  assign overrun = overrun_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: table-driven and directed checks of the I2S receiver with clk = 8 x sclk
module tb_i2s_rx;
  logic clk = 1'b0, reset, sclk, lrclk, sdin, ready, valid, overrun, frame_err;
  logic [15:0] left, right;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  i2s_rx dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .lrclk    (lrclk),
    .sdin     (sdin),
    .left     (left),
    .right    (right),
    .valid    (valid),
    .ready    (ready),
    .overrun  (overrun),
    .frame_err(frame_err)
  );
  typedef struct {
    logic [15:0] l, r;
    bit coll, acc, ev;
    logic [15:0] el, er;
    bit eo;
  } vec_t;
  vec_t tbl[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string n, input bit ev, input logic [15:0] el, input logic [15:0] er, input bit eo, input bit ef);
    chk({n, " valid"}, 32'(valid), 32'(ev));
    if (ev) begin
      chk({n, " left"}, 32'(left), 32'(el));
      chk({n, " right"}, 32'(right), 32'(er));
    end
    chk({n, " overrun"}, 32'(overrun), 32'(eo));
    chk({n, " frame_err"}, 32'(frame_err), 32'(ef));
  endtask
  task automatic send_bit(input logic l, input logic b, input bit coll);
    sclk = 1'b0;
    lrclk = l;
    sdin = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    if (coll) ready = 1'b1;
    @(negedge clk);
  endtask
  task automatic send_word(input logic ch, input logic [31:0] w, input int n, input bit coll);
    for (int i = n - 1; i >= 0; i--) send_bit(i == 0 ? ~ch : ch, w[i], coll && i == 0);
  endtask
  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input bit coll);
    send_word(1'b0, l, n, 1'b0);
    send_word(1'b1, r, n, coll);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic accept(input string n);
    ready = 1'b1;
    @(negedge clk);
    chk({n, " accept valid"}, 32'(valid), 32'd0);
    ready = 1'b0;
  endtask
  initial begin
    tbl[0] = '{16'hA5C3, 16'h0F0F, 0, 0, 1, 16'hA5C3, 16'h0F0F, 0};
    tbl[1] = '{16'h7777, 16'h8888, 1, 1, 1, 16'h7777, 16'h8888, 0};
    tbl[2] = '{16'h1111, 16'h2222, 0, 0, 1, 16'h1111, 16'h2222, 0};
    tbl[3] = '{16'h3333, 16'h4444, 0, 0, 1, 16'h1111, 16'h2222, 1};
    tbl[4] = '{16'h5555, 16'h6666, 0, 1, 1, 16'h1111, 16'h2222, 1};
    reset = 1'b1;
    ready = 1'b0;
    sclk = 1'b0;
    lrclk = 1'b0;
    sdin = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_all("reset", 0, 16'h0, 16'h0, 0, 0);
    chk("reset left", 32'(left), 32'd0);
    chk("reset right", 32'(right), 32'd0);
    repeat (100) @(negedge clk);
    chk("idle valid", 32'(valid), 32'd0);
    send_frame(32'h1234, 32'h5678, 16, 1'b0);
    chk_all("lock", 0, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      send_frame(32'(tbl[i].l), 32'(tbl[i].r), 16, tbl[i].coll);
      ready = 1'b0;
      chk_all($sformatf("t%0d", i), tbl[i].ev, tbl[i].el, tbl[i].er, tbl[i].eo, 0);
      if (tbl[i].acc) accept($sformatf("t%0d", i));
    end
    chk("overrun sticky", 32'(overrun), 32'd1);
    do_reset();
    chk_all("reset2", 0, 16'h0, 16'h0, 0, 0);
    send_frame(32'h0, 32'h0, 16, 1'b0);
    send_word(1'b0, 32'h3FF, 10, 1'b0);
    send_word(1'b1, 32'hBEEF, 16, 1'b0);
    chk_all("short", 0, 16'h0, 16'h0, 0, 1);
    send_frame(32'h9999, 32'hAAAA, 16, 1'b0);
    chk_all("after short", 1, 16'h9999, 16'hAAAA, 0, 1);
    do_reset();
    send_frame(32'h0, 32'h0, 16, 1'b0);
    send_frame(32'hDEADBEEF, 32'hCAFEF00D, 32, 1'b0);
    chk_all("long", 1, 16'hDEAD, 16'hCAFE, 0, 0);
    do_reset();
    send_frame(32'h0, 32'h0, 16, 1'b0);
    for (int i = 15; i >= 8; i--) send_bit(1'b0, i[0], 1'b0);
    do_reset();
    chk_all("mid reset", 0, 16'h0, 16'h0, 0, 0);
    send_word(1'b0, 32'h00AB, 8, 1'b0);
    send_word(1'b1, 32'h4321, 16, 1'b0);
    chk_all("relock", 0, 16'h0, 16'h0, 0, 0);
    send_frame(32'h1357, 32'h2468, 16, 1'b0);
    chk_all("after relock", 1, 16'h1357, 16'h2468, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
